serial_byte_receiver: RTL and testbench
=======================================

# serial_byte_receiver

Serial-to-parallel front end that feeds the 8-bit enable-loaded `register` stage. It oversamples an asynchronous UART-style line and assembles one LSB-first byte per frame. Each good byte is presented on `D_out` with a one-cycle `load` strobe; `D_out`/`load` connect directly to the register's `D`/`en`. Framing faults are flagged, and the faulty frame is never loaded.

## Interface
- `CLKS_PER_BIT`, default 4: clock cycles per serial bit. Must be even and ≥4; other values are unsupported.
- `CLK`  in  1  system clock, rising-edge active.
- `RST`  in  1  reset; asynchronous, active-low.
- `rx_in`  in  1  serial line; idle high; frame is start(0), 8 data bits LSB first, [parity], stop(1).
- `D_out`  out  8  last good byte; changes only in the cycle `load` is high.
- `load`  out  1  one-cycle pulse, good byte valid on `D_out`.
- `busy`  out  1  high while a frame is in progress (any state except IDLE).
- `frame_err`  out  1  one-cycle pulse, stop bit sampled 0.
- `parity_err`  out  1  one-cycle pulse, parity mismatch; constant 0 when parity is compiled out.

## Operation
- Input sync: `rx_in` passes through a 2-flop synchronizer, both flops reset to 1. Below, "rx" means the synchronizer output.
- `prev` register: holds rx from the previous cycle; reset value 1.
- States: IDLE, START, DATA, PARITY (macro only), STOP.
  - A tick counter of ceil(log2(CLKS_PER_BIT)) bits and a 3-bit bit index are used.
- IDLE:
  - Falling edge (prev=1, rx=0) → START, tick=0.
  - A line held low does not retrigger.
- START:
  - At tick = CLKS_PER_BIT/2−1, sample rx.
  - rx=1 → glitch: return to IDLE, no pulses.
  - rx=0 → DATA, tick=0, index=0.
- DATA:
  - At tick = CLKS_PER_BIT−1, shift rx into bit[index] of the shift register; index+1.
  - After index 7 → PARITY if enabled, else STOP.
- PARITY: sampled at the same tick point; compared against even parity of the 8 data bits.
- STOP: sampled at the same tick point, then return to IDLE. The next cycle emits exactly one of:
  - `load`, when stop=1 and parity is OK. `D_out` is updated in that same cycle.
  - `frame_err`, when stop=0. Takes priority over `parity_err`; `D_out` unchanged.
  - `parity_err`, when stop=1 and parity is bad; `D_out` unchanged.
- Pulse exclusivity: `load`, `frame_err` and `parity_err` are never high together.
- Reset values: `D_out`=0x00, `load`=`busy`=`frame_err`=`parity_err`=0, state IDLE, shift register 0.
- Reset mid-frame: the partial byte is discarded and no pulse is emitted.

## Timing
- T0 is the first cycle rx=0 in IDLE. rx lags `rx_in` by 2 cycles.
- Start sample: T0 + CLKS_PER_BIT/2.
- Data bit i (0..7) sample: T0 + CLKS_PER_BIT/2 + (i+1)·CLKS_PER_BIT.
- Stop sample: T0 + CLKS_PER_BIT/2 + 9·CLKS_PER_BIT (10· with parity).
- Result pulse: 1 cycle after the stop sample; state is IDLE in that cycle.
  - For CLKS_PER_BIT=4 without parity: `load` at T0+39.
- Back-to-back frames: a start edge in the cycle after the stop sample is detected. No idle gap is required beyond a valid stop bit.
- `busy` rises at T0+1 and falls in the result-pulse cycle.

## Configuration
- `RX_PARITY_EN` defined:
  - PARITY state present; frame is 11 bits.
  - Even parity: the parity bit equals the XOR of the 8 data bits.
  - `parity_err` is live.
- `RX_PARITY_EN` undefined:
  - No PARITY state; frame is 10 bits.
  - `parity_err` tied to 0.

## Test plan
- Good byte: CLKS_PER_BIT=4, no parity, send 0xA5 → single `load` at T0+39; `D_out`=0xA5; no error pulses.
- Glitch: `rx_in` low for 1 cycle → no pulses; `busy` high for ≈2 cycles then low; `D_out` unchanged.
- Frame error: after a good 0xA5, send 0x3C with stop=0 → `frame_err` pulse, no `load`; `D_out` stays 0xA5; next frame 0x11 loads normally.
- Back-to-back: 0x00 then 0xFF with no idle gap → two `load` pulses 40 cycles apart; `D_out` reads 0x00 then 0xFF.
- Reset mid-frame: assert RST during data bit 4 of 0x5A → outputs go to reset values immediately; no `load`; then 0x81 → `D_out`=0x81.
- Parity (`RX_PARITY_EN` defined): 0x07 with parity bit 1 → `load`, `D_out`=0x07; 0x07 with parity bit 0 → `parity_err`, `D_out` stays 0x07, no `load`.

Source files
------------

// File: rtl/serial_byte_receiver_if.sv
// serial_byte_receiver_if: serial line in, byte/strobe/status out of the receiver
//   rx_in      serial line, idle high
//   D_out      last good byte
//   load       one-cycle strobe, byte valid on D_out
//   busy       frame in progress
//   frame_err  one-cycle pulse, stop bit sampled low
//   parity_err one-cycle pulse, parity mismatch
// slave is the receiver side; master is the line driver / byte consumer.
interface serial_byte_receiver_if;
    logic       rx_in;
    logic [7:0] D_out;
    logic       load;
    logic       busy;
    logic       frame_err;
    logic       parity_err;
    modport master (output rx_in, input D_out, load, busy, frame_err, parity_err);
    modport slave  (input rx_in, output D_out, load, busy, frame_err, parity_err);
endinterface

// File: rtl/serial_byte_receiver.sv
// serial_byte_receiver: oversampling UART-style receiver, one LSB-first byte per frame
//   CLK  system clock, rising edge
//   RST  asynchronous active-low reset
//   bus  serial_byte_receiver_if.slave (rx_in in; D_out, load, busy, frame_err, parity_err out)
// Define RX_PARITY_EN to add an even-parity bit between data and stop.
module serial_byte_receiver #(
    parameter int CLKS_PER_BIT = 4
) (
    input  logic                         CLK,
    input  logic                         RST,
    serial_byte_receiver_if.slave        bus
);
    localparam int TW = $clog2(CLKS_PER_BIT);
    localparam logic [TW-1:0] HALF = TW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [TW-1:0] FULL = TW'(CLKS_PER_BIT - 1);
    localparam logic [2:0] IDLE  = 3'd0;
    localparam logic [2:0] START = 3'd1;
    localparam logic [2:0] DATA  = 3'd2;
    localparam logic [2:0] STOP  = 3'd4;
`ifdef RX_PARITY_EN
    localparam logic [2:0] PARITY = 3'd3;
    localparam logic [2:0] AFTER_DATA = PARITY;
`else
    localparam logic [2:0] AFTER_DATA = STOP;
`endif

    logic [1:0]    sync_q;
    logic          prev_q;
    logic [2:0]    state_q, state_d;
    logic [TW-1:0] tick_q, tick_d;
    logic [2:0]    idx_q, idx_d;
    logic [7:0]    shift_q, shift_d;
    logic [7:0]    dout_q, dout_d;
    logic          load_q, load_d;
    logic          ferr_q, ferr_d;
    logic          rx, par_ok;

    assign rx = sync_q[1];

`ifdef RX_PARITY_EN
    logic par_q, par_d;
    logic perr_q, perr_d;
    assign par_ok = (par_q == ^shift_q);
    assign bus.parity_err = perr_q;
`else
    assign par_ok = 1'b1;
    assign bus.parity_err = 1'b0;
`endif

    assign bus.D_out     = dout_q;
    assign bus.load      = load_q;
    assign bus.frame_err = ferr_q;
    assign bus.busy      = state_q != IDLE;

    always_comb begin
        state_d = state_q;
        tick_d  = tick_q + TW'(1);
        idx_d   = idx_q;
        shift_d = shift_q;
        dout_d  = dout_q;
        load_d  = 1'b0;
        ferr_d  = 1'b0;
`ifdef RX_PARITY_EN
        par_d   = par_q;
        perr_d  = 1'b0;
`endif
        case (state_q)
            IDLE: begin
                tick_d = '0;
                // Edge-triggered so a line stuck low cannot restart frames
                if (prev_q && !rx) state_d = START;
            end
            START: if (tick_q == HALF) begin
                state_d = rx ? IDLE : DATA;
                tick_d  = '0;
                idx_d   = '0;
            end
            DATA: if (tick_q == FULL) begin
                shift_d[idx_q] = rx;
                idx_d   = idx_q + 3'd1;
                tick_d  = '0;
                state_d = (idx_q == 3'd7) ? AFTER_DATA : DATA;
            end
`ifdef RX_PARITY_EN
            PARITY: if (tick_q == FULL) begin
                par_d   = rx;
                tick_d  = '0;
                state_d = STOP;
            end
`endif
            STOP: if (tick_q == FULL) begin
                // Return to IDLE mid stop bit so a following start edge is caught
                state_d = IDLE;
                tick_d  = '0;
                ferr_d  = !rx;
                load_d  = rx && par_ok;
                dout_d  = (rx && par_ok) ? shift_q : dout_q;
`ifdef RX_PARITY_EN
                perr_d  = rx && !par_ok;
`endif
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            sync_q  <= 2'b11;
            prev_q  <= 1'b1;
            state_q <= IDLE;
            tick_q  <= '0;
            idx_q   <= '0;
            shift_q <= '0;
            dout_q  <= '0;
            load_q  <= 1'b0;
            ferr_q  <= 1'b0;
        end else begin
            sync_q  <= {sync_q[0], bus.rx_in};
            prev_q  <= rx;
            state_q <= state_d;
            tick_q  <= tick_d;
            idx_q   <= idx_d;
            shift_q <= shift_d;
            dout_q  <= dout_d;
            load_q  <= load_d;
            ferr_q  <= ferr_d;
        end
    end

`ifdef RX_PARITY_EN
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            par_q  <= 1'b0;
            perr_q <= 1'b0;
        end else begin
            par_q  <= par_d;
            perr_q <= perr_d;
        end
    end
`endif
endmodule

// File: tb/tb_serial_byte_receiver.sv
// tb_serial_byte_receiver: directed and random frames against an event-level model of the receiver
module tb_serial_byte_receiver;
    localparam int C = 4;
`ifdef RX_PARITY_EN
    localparam bit PAR = 1'b1;
`else
    localparam bit PAR = 1'b0;
`endif
    localparam int NB = PAR ? 10 : 9;

    typedef struct {
        int         cyc;
        int         kind;
        logic [7:0] d;
    } ev_t;

    logic CLK = 1'b0;
    logic RST = 1'b1;
    int   cyc = 0;
    int   checks = 0;
    int   failures = 0;
    ev_t  got_q[$];
    ev_t  exp_q[$];
    logic [7:0] exp_dout = 8'h00;
    logic [7:0] prev_dout = 8'h00;
    logic prev_busy = 1'b0;
    int   rise_cyc = -1;
    int   fall_cyc = -1;
    int   busy_cnt = 0;

    serial_byte_receiver_if bus ();
    serial_byte_receiver #(.CLKS_PER_BIT(C)) dut (.CLK(CLK), .RST(RST), .bus(bus));

    always #5 CLK = ~CLK;
    always @(posedge CLK) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            failures++;
            $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    always @(negedge CLK) begin
        if (bus.load || bus.frame_err || bus.parity_err) begin
            got_q.push_back('{cyc, bus.load ? 0 : (bus.frame_err ? 1 : 2), bus.D_out});
            chk("exclusive", 32'(bus.load) + 32'(bus.frame_err) + 32'(bus.parity_err), 1);
        end
        if (RST && bus.D_out !== prev_dout) chk("dout_only_on_load", 32'(bus.load), 1);
        prev_dout = bus.D_out;
        if (bus.busy && !prev_busy) rise_cyc = cyc;
        if (!bus.busy && prev_busy) fall_cyc = cyc;
        busy_cnt += int'(bus.busy);
        prev_busy = bus.busy;
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge CLK);
            #1;
        end
    endtask

    // Model: a frame whose start bit is driven in cycle k resolves in cycle
    // k + 2 (synchronizer) + C/2 + NB*C (stop sample) + 1.
    task automatic send_frame(input logic [7:0] d, input logic stop, input logic bad, input int gap);
        int k;
        k = cyc;
        if (!stop) exp_q.push_back('{k + 3 + C / 2 + NB * C, 1, exp_dout});
        else if (PAR && bad) exp_q.push_back('{k + 3 + C / 2 + NB * C, 2, exp_dout});
        else begin
            exp_q.push_back('{k + 3 + C / 2 + NB * C, 0, d});
            exp_dout = d;
        end
        bus.rx_in = 1'b0;
        tick(C);
        for (int i = 0; i < 8; i++) begin
            bus.rx_in = d[i];
            tick(C);
        end
        if (PAR) begin
            bus.rx_in = (^d) ^ bad;
            tick(C);
        end
        bus.rx_in = stop;
        tick(C);
        bus.rx_in = 1'b1;
        tick(gap * C);
    endtask

    task automatic compare_events(input string tag);
        chk({tag, "_count"}, got_q.size(), exp_q.size());
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
            chk({tag, "_cyc"}, got_q[i].cyc, exp_q[i].cyc);
            chk({tag, "_kind"}, got_q[i].kind, exp_q[i].kind);
            chk({tag, "_data"}, 32'(got_q[i].d), 32'(exp_q[i].d));
        end
        chk({tag, "_dout"}, 32'(bus.D_out), 32'(exp_dout));
        got_q.delete();
        exp_q.delete();
    endtask

    initial begin
        int k;
        logic [7:0] d;
        logic stop, bad;
        int gap;
        bus.rx_in = 1'b1;
        #1 RST = 1'b0;
        tick(3);
        chk("rst_dout", 32'(bus.D_out), 0);
        chk("rst_load", 32'(bus.load), 0);
        chk("rst_busy", 32'(bus.busy), 0);
        chk("rst_ferr", 32'(bus.frame_err), 0);
        chk("rst_perr", 32'(bus.parity_err), 0);
        RST = 1'b1;
        tick(4);

        k = cyc;
        send_frame(8'hA5, 1'b1, 1'b0, 2);
        tick(8);
        chk("good_busy_rise", rise_cyc, k + 3);
        chk("good_busy_fall", fall_cyc, k + 3 + C / 2 + NB * C);
        compare_events("good");

        busy_cnt = 0;
        k = cyc;
        bus.rx_in = 1'b0;
        tick(1);
        bus.rx_in = 1'b1;
        tick(20);
        chk("glitch_busy_cycles", busy_cnt, C / 2);
        chk("glitch_busy_rise", rise_cyc, k + 3);
        compare_events("glitch");

        send_frame(8'h3C, 1'b0, 1'b0, 2);
        send_frame(8'h11, 1'b1, 1'b0, 2);
        tick(8);
        compare_events("frame_err");

        send_frame(8'h00, 1'b1, 1'b0, 0);
        send_frame(8'hFF, 1'b1, 1'b0, 2);
        tick(8);
        if (got_q.size() >= 2) chk("b2b_spacing", got_q[1].cyc - got_q[0].cyc, (NB + 1) * C);
        else chk("b2b_loads", got_q.size(), 2);
        compare_events("b2b");

        d = 8'h5A;
        bus.rx_in = 1'b0;
        tick(C);
        for (int i = 0; i < 4; i++) begin
            bus.rx_in = d[i];
            tick(C);
        end
        bus.rx_in = d[4];
        tick(C / 2 + 2);
        RST = 1'b0;
        #1;
        chk("midrst_dout", 32'(bus.D_out), 0);
        chk("midrst_busy", 32'(bus.busy), 0);
        chk("midrst_load", 32'(bus.load), 0);
        exp_dout = 8'h00;
        bus.rx_in = 1'b1;
        tick(2);
        RST = 1'b1;
        tick(4);
        send_frame(8'h81, 1'b1, 1'b0, 2);
        tick(8);
        compare_events("midrst");

`ifdef RX_PARITY_EN
        send_frame(8'h07, 1'b1, 1'b0, 2);
        send_frame(8'h07, 1'b1, 1'b1, 2);
        tick(8);
        compare_events("parity");
`endif

        for (int i = 0; i < 30; i++) begin
            d = 8'($urandom);
            stop = $urandom_range(7) != 0;
            bad = $urandom_range(3) == 0;
            gap = $urandom_range(2);
            if (!stop && gap == 0) gap = 1;
            send_frame(d, stop, bad, gap);
        end
        tick(60);
        compare_events("random");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
